// File: rtl/csr_regfile_if.sv
// CSR/exception interface between the WB stage (master) and the CSR file (slave).
// clk and resetn are kept as plain ports on the modules.
interface csr_regfile_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn_flush;
    logic        wb_ex;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        has_int;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               ertn_flush, wb_ex, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
               hw_int_in, ipi_int_in,
        input  csr_rvalue, ex_entry, ertn_entry, has_int
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               ertn_flush, wb_ex, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
               hw_int_in, ipi_int_in,
        output csr_rvalue, ex_entry, ertn_entry, has_int
    );
endinterface

// File: rtl/csr_regfile.sv
// LoongArch-32 CSR file: masked CSR reads/writes, exception/ertn commit, interrupt pending.
// Define CSR_TIMER_EN to build the stable timer (TCFG/TVAL/TICLR and ESTAT.IS[11]).
module csr_regfile #(
    parameter logic [31:0] TID_INIT = 32'h0
) (
    input  logic         clk,
    input  logic         resetn,
    csr_regfile_if.slave bus
);
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00c;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [31:0] WM_CRMD    = 32'h0000_01ff;
    localparam logic [31:0] WM_PRMD    = 32'h0000_0007;
    localparam logic [31:0] WM_ECFG    = 32'h0000_1bff;
    localparam logic [31:0] WM_EENTRY  = 32'hffff_ffc0;
    localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

    localparam logic [5:0]  ECODE_ADEF = 6'h08;
    localparam logic [5:0]  ECODE_ALE  = 6'h09;

    logic [31:0] crmd_q, crmd_d;
    logic [31:0] prmd_q, prmd_d;
    logic [31:0] ecfg_q, ecfg_d;
    logic [31:0] estat_q, estat_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] eentry_q, eentry_d;
    logic [31:0] tid_q, tid_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];

    logic        wr_en;
    logic [31:0] csr_cur;
    logic [31:0] wr_merged;
    logic        timer_is_d;

    // Only the writable bits take the merged value; the rest keep their current contents.
    function automatic logic [31:0] apply_wr(input logic [31:0] old,
                                             input logic [31:0] writable,
                                             input logic [31:0] merged);
        return (old & ~writable) | (merged & writable);
    endfunction

    assign wr_en     = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
    assign wr_merged = (csr_cur & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);

`ifdef CSR_TIMER_EN
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;
    logic        tcfg_wr;
    logic        ticlr_wr;
    logic        timer_fire;

    assign tcfg_wr    = wr_en & (bus.csr_num == CSR_TCFG);
    assign ticlr_wr   = wr_en & (bus.csr_num == CSR_TICLR) & bus.csr_wvalue[0] & bus.csr_wmask[0];
    assign timer_fire = ~tcfg_wr & tcfg_q[0] & (tval_q == 32'd1);
    // A set from expiry beats a same-cycle TICLR clear.
    assign timer_is_d = timer_fire ? 1'b1 : (ticlr_wr ? 1'b0 : estat_q[11]);

    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        if (tcfg_wr) begin
            tcfg_d = wr_merged;
            tval_d = {wr_merged[31:2], 2'b00};
        end else if (tcfg_q[0] && (tval_q != 32'd0)) begin
            if (timer_fire) begin
                tval_d = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'd0;
            end else begin
                tval_d = tval_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tcfg_q <= 32'd0;
            tval_q <= 32'd0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
        end
    end
`else
    assign timer_is_d = 1'b0;
`endif

    always_comb begin
        csr_cur = 32'd0;
        case (bus.csr_num)
            CSR_CRMD:   csr_cur = crmd_q;
            CSR_PRMD:   csr_cur = prmd_q;
            CSR_ECFG:   csr_cur = ecfg_q;
            CSR_ESTAT:  csr_cur = estat_q;
            CSR_ERA:    csr_cur = era_q;
            CSR_BADV:   csr_cur = badv_q;
            CSR_EENTRY: csr_cur = eentry_q;
            CSR_SAVE0:  csr_cur = save_q[0];
            CSR_SAVE1:  csr_cur = save_q[1];
            CSR_SAVE2:  csr_cur = save_q[2];
            CSR_SAVE3:  csr_cur = save_q[3];
            CSR_TID:    csr_cur = tid_q;
`ifdef CSR_TIMER_EN
            CSR_TCFG:   csr_cur = tcfg_q;
            CSR_TVAL:   csr_cur = tval_q;
`endif
            default:    csr_cur = 32'd0;
        endcase
    end

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        tid_d    = tid_q;
        save_d   = save_q;

        estat_d        = estat_q;
        estat_d[9:2]   = bus.hw_int_in;
        estat_d[11]    = timer_is_d;
        estat_d[12]    = bus.ipi_int_in;

        // wb_ex > ertn_flush > csr write; a lower-priority request is dropped entirely.
        if (bus.wb_ex) begin
            prmd_d[2:0]     = crmd_q[2:0];
            crmd_d[2:0]     = 3'b000;
            era_d           = bus.wb_pc;
            estat_d[21:16]  = bus.wb_ecode;
            estat_d[30:22]  = bus.wb_esubcode;
            if (bus.wb_ecode == ECODE_ADEF) begin
                badv_d = bus.wb_pc;
            end else if (bus.wb_ecode == ECODE_ALE) begin
                badv_d = bus.wb_vaddr;
            end
        end else if (bus.ertn_flush) begin
            crmd_d[2:0] = prmd_q[2:0];
        end else if (wr_en) begin
            case (bus.csr_num)
                CSR_CRMD:   crmd_d   = apply_wr(crmd_q, WM_CRMD, wr_merged);
                CSR_PRMD:   prmd_d   = apply_wr(prmd_q, WM_PRMD, wr_merged);
                CSR_ECFG:   ecfg_d   = apply_wr(ecfg_q, WM_ECFG, wr_merged);
                CSR_ESTAT:  estat_d[1:0] = wr_merged[1:0];
                CSR_ERA:    era_d    = wr_merged;
                CSR_BADV:   badv_d   = wr_merged;
                CSR_EENTRY: eentry_d = apply_wr(eentry_q, WM_EENTRY, wr_merged);
                CSR_SAVE0:  save_d[0] = wr_merged;
                CSR_SAVE1:  save_d[1] = wr_merged;
                CSR_SAVE2:  save_d[2] = wr_merged;
                CSR_SAVE3:  save_d[3] = wr_merged;
                CSR_TID:    tid_d    = wr_merged;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd_q   <= CRMD_RESET;
            prmd_q   <= 32'd0;
            ecfg_q   <= 32'd0;
            estat_q  <= 32'd0;
            era_q    <= 32'd0;
            badv_q   <= 32'd0;
            eentry_q <= 32'd0;
            tid_q    <= TID_INIT;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= 32'd0;
            end
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            estat_q  <= estat_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tid_q    <= tid_d;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= save_d[i];
            end
        end
    end

    assign bus.csr_rvalue = bus.csr_re ? csr_cur : 32'd0;
    assign bus.ex_entry   = eentry_q;
    assign bus.ertn_entry = era_q;
    assign bus.has_int    = crmd_q[2] & (|(estat_q[12:0] & ecfg_q[12:0]));
endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed scenarios plus random traffic against a CSR-number-indexed model.
module tb_csr_regfile;
    localparam logic [31:0] TID = 32'h0000_00a5;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    csr_regfile_if bus ();
    csr_regfile #(.TID_INIT(TID)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: register contents indexed by CSR number, plus which numbers exist.
    logic [31:0] mr   [0:127];
    bit          impl [0:127];

    function automatic logic [31:0] wmask_of(int n);
        case (n)
            'h00: return 32'h0000_01ff;
            'h01: return 32'h0000_0007;
            'h04: return 32'h0000_1bff;
            'h05: return 32'h0000_0003;
            'h06, 'h07, 'h30, 'h31, 'h32, 'h33, 'h40: return 32'hffff_ffff;
            'h0c: return 32'hffff_ffc0;
`ifdef CSR_TIMER_EN
            'h41: return 32'hffff_ffff;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) begin
            mr[i]   = 32'h0;
            impl[i] = (wmask_of(i) != 32'h0);
        end
        impl[5] = 1'b1;
`ifdef CSR_TIMER_EN
        impl['h42] = 1'b1;
`endif
        mr[0]     = 32'h8;
        mr['h40]  = TID;
    endtask

    function automatic logic [31:0] model_read(int n);
        if (n < 128 && impl[n]) return mr[n];
        return 32'h0;
    endfunction

    function automatic logic model_has_int();
        logic [31:0] cr, es, ec;
        cr = mr[0]; es = mr[5]; ec = mr[4];
        return cr[2] && ((es[12:0] & ec[12:0]) != 13'h0);
    endfunction

    task automatic model_clock();
        logic [31:0] nx [0:127];
        logic [31:0] es, cr, pr, merged, wm, tc, tv, wv_eff;
        int n;
        bit wr, fire, tcfg_wr;
        if (!resetn) begin
            model_reset();
            return;
        end
        nx = mr;
        n  = int'(bus.csr_num);
        wr = bus.csr_we && !bus.wb_ex && !bus.ertn_flush;
        es = mr[5];
        es[9:2] = bus.hw_int_in;
        es[12]  = bus.ipi_int_in;
        fire = 0;
        tcfg_wr = wr && (n == 'h41);
`ifdef CSR_TIMER_EN
        tc = mr['h41];
        tv = mr['h42];
        if (!tcfg_wr && tc[0] && tv != 0) begin
            if (tv == 1) begin
                fire = 1;
                es[11] = 1'b1;
                nx['h42] = tc[1] ? {tc[31:2], 2'b00} : 32'h0;
            end else begin
                nx['h42] = tv - 1;
            end
        end
`else
        tc = 32'h0; tv = 32'h0;
`endif
        cr = mr[0];
        pr = mr[1];
        if (bus.wb_ex) begin
            nx[1] = {29'd0, cr[2:0]};
            nx[0] = {cr[31:3], 3'b000};
            nx[6] = bus.wb_pc;
            es[21:16] = bus.wb_ecode;
            es[30:22] = bus.wb_esubcode;
            if (bus.wb_ecode == 6'h08) nx[7] = bus.wb_pc;
            else if (bus.wb_ecode == 6'h09) nx[7] = bus.wb_vaddr;
        end else if (bus.ertn_flush) begin
            nx[0] = {cr[31:3], pr[2:0]};
        end else if (wr) begin
            wv_eff = bus.csr_wvalue & bus.csr_wmask;
`ifdef CSR_TIMER_EN
            if (n == 'h44) begin
                if (wv_eff[0] && !fire) es[11] = 1'b0;
            end
`endif
            if (n < 128 && wmask_of(n) != 0) begin
                wm = wmask_of(n);
                merged = (mr[n] & ~bus.csr_wmask) | wv_eff;
                if (n == 5) es = (es & ~wm) | (merged & wm);
                else nx[n] = (mr[n] & ~wm) | (merged & wm);
                if (n == 'h41) nx['h42] = {merged[31:2], 2'b00};
            end
        end
        nx[5] = es;
        mr = nx;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare combinational outputs against the model, then advance one clock.
    task automatic tick();
        #1;
        check("rvalue", bus.csr_rvalue, bus.csr_re ? model_read(int'(bus.csr_num)) : 32'h0);
        check("ex_entry", bus.ex_entry, mr['h0c]);
        check("ertn_entry", bus.ertn_entry, mr[6]);
        check("has_int", {31'd0, bus.has_int}, {31'd0, model_has_int()});
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.csr_re      = 1'b0;
        bus.csr_num     = 14'h0;
        bus.csr_we      = 1'b0;
        bus.csr_wmask   = 32'h0;
        bus.csr_wvalue  = 32'h0;
        bus.ertn_flush  = 1'b0;
        bus.wb_ex       = 1'b0;
        bus.wb_pc       = 32'h0;
        bus.wb_ecode    = 6'h0;
        bus.wb_esubcode = 9'h0;
        bus.wb_vaddr    = 32'h0;
    endtask

    task automatic rd(logic [13:0] n, logic [31:0] exp, string tag);
        idle();
        bus.csr_re  = 1'b1;
        bus.csr_num = n;
        #1;
        check(tag, bus.csr_rvalue, exp);
        tick();
    endtask

    task automatic wr(logic [13:0] n, logic [31:0] wm, logic [31:0] wv);
        idle();
        bus.csr_we     = 1'b1;
        bus.csr_re     = 1'b1;
        bus.csr_num    = n;
        bus.csr_wmask  = wm;
        bus.csr_wvalue = wv;
        tick();
    endtask

    int nums [18] = '{'h0, 'h1, 'h2, 'h4, 'h5, 'h6, 'h7, 'hc, 'h30, 'h31, 'h32, 'h33,
                      'h40, 'h41, 'h42, 'h43, 'h44, 'h100};

    initial begin
        resetn = 1'b0;
        idle();
        bus.hw_int_in  = 8'h0;
        bus.ipi_int_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        resetn = 1'b1;

        rd(14'h000, 32'h8, "crmd_reset");
        rd(14'h040, TID, "tid_reset");
        check("has_int_reset", {31'd0, bus.has_int}, 32'h0);
        rd(14'h043, 32'h0, "unimpl_read");

        // Masked writes; same-cycle read returns the old value.
        idle();
        bus.csr_we = 1'b1; bus.csr_re = 1'b1; bus.csr_num = 14'h000;
        bus.csr_wmask = 32'h7; bus.csr_wvalue = 32'hffff_ffff;
        #1 check("crmd_old_on_write", bus.csr_rvalue, 32'h8);
        tick();
        rd(14'h000, 32'hf, "crmd_masked");
        wr(14'h004, 32'hffff_ffff, 32'hffff_ffff);
        rd(14'h004, 32'h1bff, "ecfg_masked");
        wr(14'h00c, 32'hffff_ffff, 32'h1c00_807f);
        rd(14'h00c, 32'h1c00_8040, "eentry_masked");
        wr(14'h043, 32'hffff_ffff, 32'h1234_5678);
        rd(14'h043, 32'h0, "unimpl_write_dropped");

        // Exception: ALE loads BADV from vaddr.
        idle();
        bus.wb_ex = 1'b1; bus.wb_ecode = 6'h09; bus.wb_pc = 32'h1c00_0100; bus.wb_vaddr = 32'h3;
        tick();
        rd(14'h001, 32'h7, "prmd_ex");
        rd(14'h000, 32'h8, "crmd_ex");
        rd(14'h006, 32'h1c00_0100, "era_ex");
        rd(14'h007, 32'h3, "badv_ex");
        rd(14'h005, 32'h0009_0000, "estat_ex");
        check("ex_entry", bus.ex_entry, 32'h1c00_8040);

        // ertn with a same-cycle SAVE0 write that must be dropped.
        idle();
        bus.ertn_flush = 1'b1; bus.csr_we = 1'b1; bus.csr_num = 14'h030;
        bus.csr_wmask = 32'hffff_ffff; bus.csr_wvalue = 32'h1234;
        tick();
        rd(14'h000, 32'hf, "crmd_ertn");
        check("ertn_entry", bus.ertn_entry, 32'h1c00_0100);
        rd(14'h030, 32'h0, "save0_dropped");

        // Interrupt from hw line 0 (IS[2]) with LIE[2].
        bus.hw_int_in = 8'h01;
        idle();
        tick();
        #1 check("has_int_hw", {31'd0, bus.has_int}, 32'h1);
        wr(14'h000, 32'h4, 32'h0);
        #1 check("has_int_ie_off", {31'd0, bus.has_int}, 32'h0);
        wr(14'h000, 32'h4, 32'h4);
        bus.hw_int_in = 8'h00;

`ifdef CSR_TIMER_EN
        wr(14'h041, 32'hffff_ffff, 32'hb);
        for (int k = 8; k >= 1; k--) rd(14'h042, k, "tval_count");
        rd(14'h005, 32'h0009_0800, "estat_timer_set");
        #1 check("has_int_timer", {31'd0, bus.has_int}, 32'h1);
        wr(14'h044, 32'hffff_ffff, 32'h1);
        #1 check("has_int_ticlr", {31'd0, bus.has_int}, 32'h0);
        rd(14'h005, 32'h0009_0000, "estat_ticlr");
        idle();
        repeat (4) tick();
        wr(14'h044, 32'hffff_ffff, 32'h1);
        rd(14'h005, 32'h0009_0800, "estat_ticlr_vs_expiry");
        rd(14'h042, 32'h7, "tval_reload");
`else
        wr(14'h041, 32'hffff_ffff, 32'hb);
        rd(14'h041, 32'h0, "tcfg_absent");
        rd(14'h042, 32'h0, "tval_absent");
        rd(14'h005, 32'h0009_0000, "estat_no_timer");
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            int pick;
            idle();
            bus.csr_re     = ($urandom % 2) == 0;
            bus.csr_num    = 14'(nums[$urandom_range(0, 17)]);
            bus.csr_we     = ($urandom % 3) == 0;
            bus.csr_wmask  = (($urandom % 2) == 0) ? 32'hffff_ffff : $urandom;
            bus.csr_wvalue = (bus.csr_num == 14'h041) ? 32'($urandom_range(0, 63)) : $urandom;
            bus.wb_ex      = ($urandom % 16) == 0;
            bus.ertn_flush = ($urandom % 12) == 0;
            pick           = $urandom_range(0, 2);
            bus.wb_ecode   = (pick == 0) ? 6'h08 : (pick == 1) ? 6'h09 : 6'($urandom);
            bus.wb_esubcode = 9'($urandom);
            bus.wb_pc      = $urandom;
            bus.wb_vaddr   = $urandom;
            if (($urandom % 8) == 0) bus.hw_int_in = 8'($urandom);
            if (($urandom % 8) == 0) bus.ipi_int_in = 1'($urandom);
            tick();
        end

        // Reset in the middle of operation.
        bus.hw_int_in = 8'h00;
        bus.ipi_int_in = 1'b0;
        wr(14'h00c, 32'hffff_ffff, 32'h8000_0040);
        wr(14'h041, 32'hffff_ffff, 32'hb);
        idle();
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        check("ex_entry_rst", bus.ex_entry, 32'h0);
        check("ertn_entry_rst", bus.ertn_entry, 32'h0);
        check("has_int_rst", {31'd0, bus.has_int}, 32'h0);
        rd(14'h041, 32'h0, "tcfg_rst");
        rd(14'h042, 32'h0, "tval_rst");
        rd(14'h000, 32'h8, "crmd_rst");
        rd(14'h040, TID, "tid_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
